mc_ctrl: RTL and testbench

//  Multi-cycle control FSM for the MIPS-subset datapath (PC/IM/GRF/ALU/DM).

---
 rtl/mc_pkg.sv | 87 ++++++++
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_decode.sv | 71 +++++++
 rtl/mc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package mc_pkg;

  // FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  // Instruction classes as seen by the sequencer.
  typedef enum logic [2:0] {
    CL_ALU   = 3'd0,
    CL_LOAD  = 3'd1,
    CL_STORE = 3'd2,
    CL_BEQ   = 3'd3,
    CL_LUI   = 3'd4,
    CL_JAL   = 3'd5,
    CL_JR    = 3'd6
  } class_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // ALU function codes, matching the datapath ALU
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;

  // ALU B-operand selects
  localparam logic [2:0] B_READ2 = 3'd0;
  localparam logic [2:0] B_SEXT  = 3'd1;
  localparam logic [2:0] B_ZEXT  = 3'd2;
  localparam logic [2:0] B_SHAMT = 3'd3;

  // Next-PC selects
  localparam logic [2:0] NPC_SEQ  = 3'd0;
  localparam logic [2:0] NPC_BEQ  = 3'd1;
  localparam logic [2:0] NPC_JUMP = 3'd2;
  localparam logic [2:0] NPC_REG  = 3'd3;

  // GRF write-address selects
  localparam logic [1:0] RA_RD = 2'd0;
  localparam logic [1:0] RA_RT = 2'd1;
  localparam logic [1:0] RA_31 = 2'd2;

  // GRF write-data selects
  localparam logic [2:0] RD_ALU  = 3'd0;
  localparam logic [2:0] RD_DM   = 3'd1;
  localparam logic [2:0] RD_LUI  = 3'd2;
  localparam logic [2:0] RD_PC4  = 3'd3;
  localparam logic [2:0] RD_HALF = 3'd4;
  localparam logic [2:0] RD_SLT  = 3'd5;

  // Everything the sequencer needs to know about the latched instruction.
  typedef struct packed {
    class_t     cls;
    logic       illegal;
    logic [2:0] alu_op;
    logic [2:0] alu_b_op;
    logic       a1_op;
    logic [1:0] reg_addr_op;
    logic [2:0] reg_data_op;
    logic [2:0] wb_npc_op;
  } dec_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction/DM handshake in, selects out.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             mem_ready;
  logic             pc_write;
  logic [2:0]       next_pc_op;
  logic             reg_write;
  logic             a1_op;
  logic [1:0]       reg_addr_op;
  logic [2:0]       reg_data_op;
  logic [2:0]       alu_op;
  logic [2:0]       alu_b_op;
  logic             mem_req;
  logic             mem_write;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state;

  modport master (
    input  instr, mem_ready,
    output pc_write, next_pc_op, reg_write, a1_op, reg_addr_op, reg_data_op,
           alu_op, alu_b_op, mem_req, mem_write, retire, illegal,
           instr_count, state
  );

  modport slave (
    output instr, mem_ready,
    input  pc_write, next_pc_op, reg_write, a1_op, reg_addr_op, reg_data_op,
           alu_op, alu_b_op, mem_req, mem_write, retire, illegal,
           instr_count, state
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational decoder: opcode/funct of the latched IR -> class and selects.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Table lookup; anything not listed is flagged illegal.
  always_comb begin
    dec = '0;
    dec.cls = CL_ALU;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_ADD: dec.alu_op = ALU_ADD;
          FN_SUBU, FN_SUB: dec.alu_op = ALU_SUB;
          FN_SLT: begin
            dec.alu_op      = ALU_SUB;
            dec.reg_data_op = RD_SLT;
          end
          FN_SLL: begin
            dec.alu_op   = ALU_SLL;
            dec.alu_b_op = B_SHAMT;
            dec.a1_op    = 1'b1;
          end
          FN_JR: begin
            dec.cls       = CL_JR;
            dec.wb_npc_op = NPC_REG;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        dec.alu_op      = ALU_OR;
        dec.alu_b_op    = B_ZEXT;
        dec.reg_addr_op = RA_RT;
      end
      OP_LUI: begin
        dec.cls         = CL_LUI;
        dec.reg_addr_op = RA_RT;
        dec.reg_data_op = RD_LUI;
      end
      OP_LW, OP_LH: begin
        dec.cls         = CL_LOAD;
        dec.alu_op      = ALU_ADD;
        dec.alu_b_op    = B_SEXT;
        dec.reg_addr_op = RA_RT;
        dec.reg_data_op = (op == OP_LW) ? RD_DM : RD_HALF;
      end
      OP_SW: begin
        dec.cls      = CL_STORE;
        dec.alu_op   = ALU_ADD;
        dec.alu_b_op = B_SEXT;
      end
      OP_BEQ: begin
        dec.cls    = CL_BEQ;
        dec.alu_op = ALU_SUB;
      end
      OP_JAL: begin
        dec.cls         = CL_JAL;
        dec.reg_addr_op = RA_31;
        dec.reg_data_op = RD_PC4;
        dec.wb_npc_op   = NPC_JUMP;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing with DM
// handshake, optional MEM timeout, illegal-instruction trap, retire counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic      clk,
  input  logic      reset,
  mc_ctrl_if.master bus
);

  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [31:0] WAIT_LAST  = TIMEOUT_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

  state_t           state_reg, state_next;
  logic [31:0]      wait_reg, wait_next;
  logic [5:0]       ir_op_reg, ir_funct_reg;
  logic [CNT_W-1:0] count_reg;
  dec_t             dec;

  logic       pc_write, reg_write, a1_op, mem_req, mem_write, retire, illegal;
  logic [2:0] next_pc_op, reg_data_op, alu_op, alu_b_op;
  logic [1:0] reg_addr_op;

  // Operand fields go straight from IM to the datapath; only op/funct are kept here.
  logic instr_unused;
  assign instr_unused = ^bus.instr[25:6];

  mc_decode u_decode (
    .op    (ir_op_reg),
    .funct (ir_funct_reg),
    .dec   (dec)
  );

  // State register and MEM wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  // Instruction register (op/funct) and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_op_reg    <= '0;
      ir_funct_reg <= '0;
      count_reg    <= '0;
    end else begin
      if (state_reg == FETCH) begin
        ir_op_reg    <= bus.instr[31:26];
        ir_funct_reg <= bus.instr[5:0];
      end
      if (retire) count_reg <= count_reg + 1'b1;
    end
  end

  // Next-state logic, including the bounded MEM wait.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (dec.illegal)                             state_next = TRAP;
        else if (dec.cls inside {CL_LUI, CL_JAL, CL_JR}) state_next = WB;
        else                                         state_next = EXEC;
      end
      EXEC: begin
        if (dec.cls == CL_BEQ)                          state_next = FETCH;
        else if (dec.cls inside {CL_LOAD, CL_STORE})    state_next = MEM;
        else                                            state_next = WB;
      end
      MEM: begin
        if (bus.mem_ready) begin
          wait_next  = '0;
          state_next = (dec.cls == CL_STORE) ? FETCH : WB;
        end else if (TIMEOUT_EN && wait_reg == WAIT_LAST) begin
          wait_next  = '0;
          state_next = TRAP;
        end else if (TIMEOUT_EN) begin
          wait_next = wait_reg + 32'd1;
        end
      end
      WB:      state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  // Moore-style select outputs; only the sw retire in MEM follows mem_ready.
  always_comb begin
    pc_write    = 1'b0;
    next_pc_op  = NPC_SEQ;
    reg_write   = 1'b0;
    a1_op       = 1'b0;
    reg_addr_op = RA_RD;
    reg_data_op = RD_ALU;
    alu_op      = ALU_ADD;
    alu_b_op    = B_READ2;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    // ALU selects held from EXEC through WB so the address/result stays valid.
    if (state_reg inside {EXEC, MEM, WB}) begin
      alu_op   = dec.alu_op;
      alu_b_op = dec.alu_b_op;
      a1_op    = dec.a1_op;
    end
    case (state_reg)
      EXEC: begin
        if (dec.cls == CL_BEQ) begin
          pc_write   = 1'b1;
          next_pc_op = NPC_BEQ;
          retire     = 1'b1;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_write = (dec.cls == CL_STORE);
        if (bus.mem_ready && dec.cls == CL_STORE) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      WB: begin
        reg_write   = (dec.cls != CL_JR);
        pc_write    = 1'b1;
        retire      = 1'b1;
        reg_addr_op = dec.reg_addr_op;
        reg_data_op = dec.reg_data_op;
        next_pc_op  = dec.wb_npc_op;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc_write    = pc_write;
  assign bus.next_pc_op  = next_pc_op;
  assign bus.reg_write   = reg_write;
  assign bus.a1_op       = a1_op;
  assign bus.reg_addr_op = reg_addr_op;
  assign bus.reg_data_op = reg_data_op;
  assign bus.alu_op      = alu_op;
  assign bus.alu_b_op    = alu_b_op;
  assign bus.mem_req     = mem_req;
  assign bus.mem_write   = mem_write;
  assign bus.retire      = retire;
  assign bus.illegal     = illegal;
  assign bus.instr_count = count_reg;
  assign bus.state       = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes expected retire records,
// a negedge monitor pops and compares whenever retire is seen.
module tb_mc_ctrl;
  import mc_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]      ir;
    logic [2:0]       st;
    logic             rw;
    logic [1:0]       ra;
    logic [2:0]       rd;
    logic [2:0]       npc;
    logic [CNT_W-1:0] cnt;
    int               lat;
  } exp_t;

  exp_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               fetch_cyc = 0;
  logic [CNT_W-1:0] exp_count = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: compare every retire pulse against the oldest expected record.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.state == 3'd0) fetch_cyc = cyc;
        if (bus.retire === 1'b1) begin
          lat = cyc - fetch_cyc + 1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_retire got state=%0d want no retire", bus.state);
          end else begin
            e = exp_q.pop_front();
            if (bus.state !== e.st || bus.reg_write !== e.rw || bus.reg_addr_op !== e.ra ||
                bus.reg_data_op !== e.rd || bus.next_pc_op !== e.npc || bus.pc_write !== 1'b1 ||
                bus.instr_count !== e.cnt || lat != e.lat)
            begin
              errors++;
              $display("FAIL retire_%h got st=%0d rw=%0d ra=%0d rd=%0d npc=%0d pcw=%0d cnt=%0d lat=%0d want st=%0d rw=%0d ra=%0d rd=%0d npc=%0d pcw=1 cnt=%0d lat=%0d",
                       e.ir, bus.state, bus.reg_write, bus.reg_addr_op, bus.reg_data_op,
                       bus.next_pc_op, bus.pc_write, bus.instr_count, lat,
                       e.st, e.rw, e.ra, e.rd, e.npc, e.cnt, e.lat);
            end else begin
              $display("retire ir=%h state=%0d lat=%0d count=%0d", e.ir, e.st, lat, e.cnt);
            end
          end
        end
      end
      cyc++;
    end
  end

  // Issue one instruction from FETCH and drive mem_ready after rdy_delay waits.
  task automatic run(input logic [31:0] ir, input int rdy_delay,
                     input logic [2:0] st, input logic rw, input logic [1:0] ra,
                     input logic [2:0] rd, input logic [2:0] npc, input int lat,
                     input logic [2:0] alu, input logic [2:0] bsel, input logic a1,
                     input int mem_n, input logic mw);
    exp_t e;
    int   n = 0;
    int   mem_got = 0;
    bit   done = 0;
    e.ir = ir; e.st = st; e.rw = rw; e.ra = ra; e.rd = rd; e.npc = npc;
    e.cnt = exp_count; e.lat = lat;
    exp_q.push_back(e);
    exp_count = exp_count + 1'b1;
    bus.instr = ir;
    bus.mem_ready = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      n++;
      case (bus.state)
        3'd1: chk("decode_quiet", 32'({bus.pc_write, bus.reg_write, bus.mem_req}), 32'd0);
        3'd2: chk("exec_alu", 32'({bus.alu_op, bus.alu_b_op, bus.a1_op}), 32'({alu, bsel, a1}));
        3'd3: begin
          mem_got++;
          chk("mem_req", 32'({bus.mem_req, bus.mem_write}), 32'({1'b1, mw}));
          bus.mem_ready = (mem_got > rdy_delay);
        end
        default: ;
      endcase
      if (bus.state != 3'd3) bus.mem_ready = 1'b0;
      if (bus.state == 3'd0 || bus.state == 3'd5 || n >= 40) done = 1;
    end
    chk("end_in_fetch", 32'(bus.state), 32'd0);
    chk("mem_cycles", 32'(mem_got), 32'(mem_n));
  endtask

  // Advance until the given state is reached or the bound expires.
  task automatic wait_state(input logic [2:0] target, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.state != target && n < limit);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    bus.instr = 32'h0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'({bus.state, bus.illegal, bus.pc_write, bus.reg_write, bus.mem_req,
                            bus.mem_write, bus.retire, bus.instr_count}), 32'd0);
    reset = 1'b1;

    //   instr         dly  st  rw ra rd npc lat alu bsel a1 mem mw
    run(32'h00221821, 0, 4, 1, 0, 0, 0, 4, 0, 0, 0, 0, 0);  // addu
    run(32'h8C430004, 2, 4, 1, 1, 1, 0, 7, 0, 1, 0, 3, 0);  // lw, 2 waits
    run(32'h10220003, 0, 2, 0, 0, 0, 1, 3, 1, 0, 0, 0, 0);  // beq
    run(32'h0C000010, 0, 4, 1, 2, 3, 2, 3, 0, 0, 0, 0, 0);  // jal
    run(32'h3C01ABCD, 0, 4, 1, 1, 2, 0, 3, 0, 0, 0, 0, 0);  // lui
    run(32'h03E00008, 0, 4, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0);  // jr
    run(32'h34220005, 0, 4, 1, 1, 0, 0, 4, 2, 2, 0, 0, 0);  // ori
    run(32'hAC430008, 0, 3, 0, 0, 0, 0, 4, 0, 1, 0, 1, 1);  // sw
    run(32'h84430002, 1, 4, 1, 1, 4, 0, 6, 0, 1, 0, 2, 0);  // lh, 1 wait
    run(32'h00021080, 0, 4, 1, 0, 0, 0, 4, 3, 3, 1, 0, 0);  // sll
    run(32'h0022182A, 0, 4, 1, 0, 5, 0, 4, 1, 0, 0, 0, 0);  // slt
    run(32'h00221823, 0, 4, 1, 0, 0, 0, 4, 1, 0, 0, 0, 0);  // subu

    // Illegal opcode traps right after DECODE and stays there.
    bus.instr = 32'hFC000000;
    wait_state(3'd5, 10, n);
    chk("trap_entry_cycles", 32'(n), 32'd2);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      @(posedge clk); #1;
      chk("trap_hold", 32'({bus.state, bus.illegal, bus.pc_write, bus.reg_write, bus.mem_req,
                            bus.mem_write, bus.retire, bus.instr_count}),
          32'({3'd5, 1'b1, 5'd0, exp_count}));
    end
    bus.mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("trap_reset", 32'({bus.state, bus.illegal, bus.instr_count}), 32'd0);
    exp_count = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Store aborted by reset while waiting in MEM.
    bus.instr = 32'hAC430008;
    wait_state(3'd3, 10, n);
    chk("sw_in_mem", 32'({bus.state, bus.mem_req, bus.mem_write}), 32'({3'd3, 2'b11}));
    reset = 1'b0;
    #1;
    chk("sw_abort", 32'({bus.state, bus.mem_req, bus.mem_write, bus.retire, bus.instr_count}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Store with mem_ready never arriving: TRAP after 4 MEM cycles.
    bus.instr = 32'hAC430008;
    wait_state(3'd3, 10, n);
    n = 0;
    while (bus.state == 3'd3 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_mem_cycles", 32'(n), 32'd4);
    chk("timeout_trap", 32'({bus.state, bus.illegal, bus.mem_req, bus.instr_count}),
        32'({3'd5, 1'b1, 1'b0, 4'd0}));
    reset = 1'b0;
    #1;
    exp_count = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Seventeen nops carry the 4-bit counter through its wrap.
    for (int i = 0; i < 17; i++) run(32'h00000000, 0, 4, 1, 0, 0, 0, 4, 3, 3, 1, 0, 0);
    @(negedge clk);
    chk("count_wrapped", 32'(bus.instr_count), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
